// File: rtl/mvu_readout_dma.sv
// mvu_readout_dma: single-command read initiator for the MVU rdc_* port, returned words buffered
// in a credit-limited FIFO. Optional build macro MVU_RDDMA_STRIDE_EN adds a per-command cmd_stride.
module mvu_readout_dma #(
  parameter int NMVU       = 8,
  parameter int N          = 64,
  parameter int BDBANKA    = 15,
  parameter int BLEN       = 16,
  parameter int RDLAT      = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int BMVUA     = $clog2(NMVU)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [BMVUA-1:0]        cmd_mvu,
  input  logic [BDBANKA-1:0]      cmd_base,
`ifdef MVU_RDDMA_STRIDE_EN
  input  logic [BDBANKA-1:0]      cmd_stride,
`endif
  input  logic [BLEN-1:0]         cmd_len,
  output logic [NMVU-1:0]         rdc_en,
  input  logic [NMVU-1:0]         rdc_grnt,
  output logic [NMVU*BDBANKA-1:0] rdc_addr,
  input  logic [NMVU*N-1:0]       rdc_word,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0]            out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + RDLAT + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

  state_t               state_r, state_nxt_s;
  logic                 cmd_ready_r;
  logic [BMVUA-1:0]     mvu_r;
  logic [BDBANKA-1:0]   addr_r, stride_s;
  logic [BLEN-1:0]      remain_r;
  logic [RDLAT-1:0]     vld_r, lst_r;
  logic [N-1:0]         fifo_data_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_r;
  logic [PW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]        fifo_cnt_r, inflight_s;
  logic                 cmd_acc_s, credit_s, issue_en_s, rd_acc_s, last_rd_s;
  logic                 push_s, pop_s, head_last_s;
  logic [N-1:0]         ret_word_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) return '0;
    else return p + PW'(1'b1);
  endfunction

  assign cmd_acc_s   = cmd_valid && cmd_ready_r;
  // Words already accepted but not yet popped may never exceed the buffer size
  assign credit_s    = (fifo_cnt_r + inflight_s) < CW'(FIFO_DEPTH);
  assign issue_en_s  = (state_r == S_ISSUE) && credit_s;
  assign rd_acc_s    = issue_en_s && rdc_grnt[mvu_r];
  assign last_rd_s   = rd_acc_s && (remain_r == BLEN'(1'b1));
  assign push_s      = vld_r[RDLAT-1];
  assign ret_word_s  = rdc_word[int'(mvu_r)*N +: N];
  assign pop_s       = out_valid && out_ready;
  assign head_last_s = fifo_last_r[rd_ptr_r];
  assign cmd_ready   = cmd_ready_r;

`ifdef MVU_RDDMA_STRIDE_EN
  logic [BDBANKA-1:0] stride_r;
  // Stride is captured together with the command
  always_ff @(posedge clk) begin
    if (rst) stride_r <= '0;
    else if (cmd_acc_s) stride_r <= cmd_stride;
  end
  assign stride_s = stride_r;
`else
  assign stride_s = BDBANKA'(1'b1);
`endif

  // State register; cmd_ready is registered so it stays low on the cycle after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      cmd_ready_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cmd_ready_r <= (state_nxt_s == S_IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (cmd_acc_s) state_nxt_s = (cmd_len == '0) ? S_DONE : S_ISSUE;
        else state_nxt_s = S_IDLE;
      end
      S_ISSUE: begin
        if (last_rd_s) state_nxt_s = S_DRAIN;
        else state_nxt_s = S_ISSUE;
      end
      S_DRAIN: begin
        if (pop_s && head_last_s) state_nxt_s = S_DONE;
        else state_nxt_s = S_DRAIN;
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Read request outputs and status decode
  always_comb begin
    rdc_en   = '0;
    rdc_addr = '0;
    if (issue_en_s) begin
      rdc_en[mvu_r] = 1'b1;
      rdc_addr[int'(mvu_r)*BDBANKA +: BDBANKA] = addr_r;
    end else begin
      rdc_en   = '0;
      rdc_addr = '0;
    end
    busy = (state_r != S_IDLE);
    done = (state_r == S_DONE);
  end

  // Command capture and per-grant address/count advance
  always_ff @(posedge clk) begin
    if (rst) begin
      mvu_r    <= '0;
      addr_r   <= '0;
      remain_r <= '0;
    end else if (cmd_acc_s) begin
      mvu_r    <= cmd_mvu;
      addr_r   <= cmd_base;
      remain_r <= cmd_len;
    end else if (rd_acc_s) begin
      addr_r   <= addr_r + stride_s;
      remain_r <= remain_r - BLEN'(1'b1);
    end
  end

  // Count of reads granted whose data has not yet been pushed
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < RDLAT; i++) inflight_s = inflight_s + CW'(vld_r[i]);
  end

  // Return tracker: a bit enters per grant and reaches the top when rdc_word is valid
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= '0;
      lst_r <= '0;
    end else begin
      vld_r[0] <= rd_acc_s;
      lst_r[0] <= last_rd_s;
      for (int i = 1; i < RDLAT; i++) begin
        vld_r[i] <= vld_r[i-1];
        lst_r[i] <= lst_r[i-1];
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
    end else begin
      if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      if (push_s && !pop_s) fifo_cnt_r <= fifo_cnt_r + CW'(1'b1);
      else if (!push_s && pop_s) fifo_cnt_r <= fifo_cnt_r - CW'(1'b1);
    end
  end

  // FIFO storage; contents are only observed through the occupancy-gated head
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_data_r[wr_ptr_r] <= ret_word_s;
      fifo_last_r[wr_ptr_r] <= lst_r[RDLAT-1];
    end
  end

  // Output port driven from the FIFO head
  always_comb begin
    out_valid = (fifo_cnt_r != '0);
    if (out_valid) begin
      out_data = fifo_data_r[rd_ptr_r];
      out_last = head_last_s;
    end else begin
      out_data = '0;
      out_last = 1'b0;
    end
  end
endmodule

// File: tb/tb_mvu_readout_dma.sv
// Bench for mvu_readout_dma: bank responder plus a queue-based model of command/word ordering,
// credit limit and return latency, compared every cycle; directed cases followed by random ones.
module tb_mvu_readout_dma;
  localparam int NMVU = 8, N = 64, BA = 15, BLEN = 16, RDLAT = 2, DEPTH = 4;

  logic                 clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_ready;
  logic [2:0]           cmd_mvu = 3'd0;
  logic [BA-1:0]        cmd_base = '0;
  logic [BLEN-1:0]      cmd_len = '0;
`ifdef MVU_RDDMA_STRIDE_EN
  logic [BA-1:0]        cmd_stride = 15'd1;
`endif
  logic [NMVU-1:0]      rdc_en, rdc_grnt = '0;
  logic [NMVU*BA-1:0]   rdc_addr;
  logic [NMVU*N-1:0]    rdc_word = '0;
  logic                 out_valid, out_ready = 1'b0, out_last, busy, done;
  logic [N-1:0]         out_data;

  mvu_readout_dma dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mvu(cmd_mvu), .cmd_base(cmd_base),
`ifdef MVU_RDDMA_STRIDE_EN
    .cmd_stride(cmd_stride),
`endif
    .cmd_len(cmd_len), .rdc_en(rdc_en), .rdc_grnt(rdc_grnt), .rdc_addr(rdc_addr),
    .rdc_word(rdc_word), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0, phase = 0, cmd_no = 0;
  bit rst_req = 1'b1, rst_prev = 1'b1, want_cmd = 1'b0;
  int c_mvu = 0, c_base = 0, c_len = 0, c_stride = 1, gmode = 0, rmode = 0, gdel = 0;
  int m_mvu = 0, remaining = 0, acc_cnt = 0, pop_cnt = 0, avail = 0;
  int exp_addr[$];
  logic [N:0] exp_out[$];
  bit bus_v[8];
  logic [N-1:0] bus_d[8];
  int bus_m[8];
  int vis[8];
  int alog[$], acyc[$];
  int req_cyc, acc_cyc, done_cyc, lpop_cyc, dcount, opops;
  logic [15:0] olast;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] word_of(input int cno, input int m, input int a);
    logic [31:0] h;
    h = 32'(cno) * 32'h9E3779B1;
    return {h, 13'd0, 3'(m), 1'b0, 15'(a)};
  endfunction

  function automatic int pick_stride();
`ifdef MVU_RDDMA_STRIDE_EN
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 1;
`else
    return 1;
`endif
  endfunction

  // One clock cycle: drive inputs at the falling edge, check outputs, advance the model
  task automatic step();
    logic [NMVU-1:0]    e_en;
    logic [NMVU*BA-1:0] e_addr;
    logic [N:0]         head;
    bit e_ov, acc, pop;
    int s, nphase, a;
    @(negedge clk);
    cyc++;
    rst_prev = rst;
    rst = rst_req;
    s = cyc % 8;
    for (int i = 0; i < NMVU; i++) rdc_word[i*N +: N] = {$urandom, $urandom};
    if (bus_v[s]) begin
      rdc_word[bus_m[s]*N +: N] = bus_d[s];
      bus_v[s] = 1'b0;
    end
    if (rst) begin
      rdc_grnt = '0; out_ready = 1'b0; cmd_valid = 1'b0;
      phase = 0; want_cmd = 1'b0; remaining = 0; acc_cnt = 0; pop_cnt = 0; avail = 0;
      exp_addr.delete(); exp_out.delete();
      for (int i = 0; i < 8; i++) vis[i] = 0;
      return;
    end
    avail += vis[s];
    vis[s] = 0;

    e_en = '0;
    e_addr = '0;
    if (phase == 1 && remaining > 0 && (acc_cnt - pop_cnt) < DEPTH) begin
      e_en[m_mvu] = 1'b1;
      e_addr[m_mvu*BA +: BA] = BA'(exp_addr[0]);
    end
    rdc_grnt = NMVU'($urandom);
    case (gmode)
      0: rdc_grnt[m_mvu] = 1'b1;
      1: rdc_grnt[m_mvu] = 1'($urandom_range(0, 1));
      default: begin
        if (e_en[m_mvu] && gdel < 5) begin
          rdc_grnt[m_mvu] = 1'b0;
          gdel++;
        end else rdc_grnt[m_mvu] = 1'b1;
      end
    endcase
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
    cmd_valid = want_cmd;
    cmd_mvu = 3'(c_mvu);
    cmd_base = BA'(c_base);
    cmd_len = BLEN'(c_len);
`ifdef MVU_RDDMA_STRIDE_EN
    cmd_stride = BA'(c_stride);
`endif

    e_ov = (avail > 0);
    chk("cmd_ready", cmd_ready, (phase == 0 && !rst_prev));
    chk("busy", busy, (phase != 0));
    chk("done", done, (phase == 2));
    chk("rdc_en", rdc_en, e_en);
    chk("rdc_addr", rdc_addr, e_addr);
    chk("out_valid", out_valid, e_ov);
    if (e_ov) begin
      head = exp_out[0];
      chk("out_data", out_data, head[N-1:0]);
      chk("out_last", out_last, head[N]);
    end
    if (rst_prev) begin
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
    end
    if (rdc_en != '0 && req_cyc < 0) req_cyc = cyc;
    if (done) begin
      dcount++;
      done_cyc = cyc;
    end

    acc = e_en[m_mvu] && rdc_grnt[m_mvu];
    pop = e_ov && out_ready;
    nphase = (phase == 2) ? 0 : phase;
    if (acc) begin
      alog.push_back(int'(rdc_addr[m_mvu*BA +: BA]));
      acyc.push_back(cyc);
      bus_v[(cyc + RDLAT) % 8] = 1'b1;
      bus_d[(cyc + RDLAT) % 8] = word_of(cmd_no, m_mvu, exp_addr[0]);
      bus_m[(cyc + RDLAT) % 8] = m_mvu;
      vis[(cyc + RDLAT + 1) % 8]++;
      void'(exp_addr.pop_front());
      remaining--;
      acc_cnt++;
    end
    if (pop) begin
      head = exp_out.pop_front();
      opops++;
      olast = {olast[14:0], out_last};
      lpop_cyc = cyc;
      pop_cnt++;
      avail--;
      if (head[N]) nphase = 2;
    end
    if (phase == 0 && !rst_prev && want_cmd) begin
      cmd_no++;
      m_mvu = c_mvu;
      remaining = c_len;
      acc_cnt = 0; pop_cnt = 0; gdel = 0;
      acc_cyc = cyc;
      for (int k = 0; k < c_len; k++) begin
        a = (c_base + k * c_stride) & 32'h7FFF;
        exp_addr.push_back(a);
        exp_out.push_back({(k == c_len - 1), word_of(cmd_no, c_mvu, a)});
      end
      nphase = (c_len == 0) ? 2 : 1;
      want_cmd = 1'b0;
    end
    phase = nphase;
  endtask

  task automatic start_cmd(input int m, input int base, input int len, input int stride,
                           input int gm, input int rm);
    c_mvu = m; c_base = base; c_len = len; c_stride = stride; gmode = gm; rmode = rm;
    want_cmd = 1'b1;
    alog.delete(); acyc.delete();
    req_cyc = -1; acc_cyc = -1; done_cyc = -1; lpop_cyc = -1;
    dcount = 0; opops = 0; olast = '0;
  endtask

  task automatic finish_cmd();
    int k;
    k = 0;
    while ((want_cmd || phase != 0) && k < 500) begin
      step();
      k++;
    end
    chk("cmd_complete", (want_cmd || phase != 0), 0);
  endtask

  task automatic run_cmd(input int m, input int base, input int len, input int stride,
                         input int gm, input int rm);
    start_cmd(m, base, len, stride, gm, rm);
    finish_cmd();
  endtask

  function automatic int alog_at(input int k);
    return (k < alog.size()) ? alog[k] : -1;
  endfunction

  initial begin
    repeat (3) step();
    rst_req = 1'b0;
    step();

    // Basic: MVU 3, four words from 0x10, free-running grant and ready
    run_cmd(3, 'h10, 4, 1, 0, 0);
    chk("t1_reads", alog.size(), 4);
    for (int k = 0; k < 4; k++) chk("t1_addr", alog_at(k), 'h10 + k);
    chk("t1_back_to_back", (acyc.size() == 4) ? acyc[3] - acyc[0] : -1, 3);
    chk("t1_words", opops, 4);
    chk("t1_last_flags", olast[3:0], 4'b0001);
    chk("t1_done_pulses", dcount, 1);
    chk("t1_done_after_pop", done_cyc - lpop_cyc, 1);

    // Grant withheld for five requested cycles
    run_cmd(3, 'h100, 3, 1, 2, 0);
    chk("t2_grant_wait", (acyc.size() > 0) ? acyc[0] - req_cyc : -1, 5);
    chk("t2_first_addr", alog_at(0), 'h100);
    chk("t2_words", opops, 3);

    // Consumer stalled: only the buffer depth worth of reads may go out
    start_cmd(2, 'h40, 8, 1, 0, 2);
    repeat (20) step();
    chk("t3_stalled_reads", acc_cnt, 4);
    chk("t3_stalled_en", rdc_en, 0);
    rmode = 0;
    finish_cmd();
    chk("t3_reads", alog.size(), 8);
    chk("t3_words", opops, 8);

    // Address wrap at the top of the bank
    run_cmd(5, 'h7FFE, 3, 1, 0, 0);
    chk("t4_addr0", alog_at(0), 'h7FFE);
    chk("t4_addr1", alog_at(1), 'h7FFF);
    chk("t4_addr2", alog_at(2), 'h0000);

    // Zero-length command
    run_cmd(1, 'h55, 0, 1, 0, 0);
    chk("t5_reads", alog.size(), 0);
    chk("t5_requests", req_cyc, -1);
    chk("t5_words", opops, 0);
    chk("t5_done_latency", done_cyc - acc_cyc, 1);
    step();

    // Reset with two reads in flight; their late returns must vanish
    start_cmd(6, 'h200, 8, 1, 0, 2);
    for (int k = 0; k < 20 && acc_cnt < 2; k++) step();
    chk("t6_inflight", acc_cnt, 2);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    opops = 0;
    repeat (6) step();
    chk("t6_stale_words", opops, 0);
    run_cmd(6, 'h20, 5, 1, 1, 1);
    chk("t6_after_rst_words", opops, 5);

    // Randomized commands, grants and back-pressure
    for (int t = 0; t < 40; t++) begin
      int b;
      b = ($urandom_range(0, 3) == 0) ? int'(32'h7FF8 + $urandom_range(0, 7))
                                      : int'($urandom_range(0, 32'h7FFF));
      run_cmd(int'($urandom_range(0, 7)), b, int'($urandom_range(0, 10)), pick_stride(), 1, 1);
    end
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
